mcp3x08_scanner: RTL and testbench

// Parametrised multi-channel SPI scanner for MCP3004/3008/3204/3208 ADCs; successor to single-shot sampler.
// On a start edge, converts every channel enabled in ch_mask in ascending order, one CS frame per channel.

---
 rtl/mcp3x08_scanner.sv | 257 +++++++++++++++++++++++++
 tb/tb_mcp3x08_scanner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3x08_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : mcp3x08_scanner                                            |
// | Description : Multi-channel SPI scan engine for MCP3004/3008/3204/3208.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mcp3x08_scanner #(
    parameter int DATA_BITS = 10,
    parameter int N_CH      = 8,
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 8,
    parameter int DIFF      = 0
) (
    input  logic                      dclk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [N_CH-1:0]           ch_mask,
    output logic                      sclk,
    output logic                      din,
    input  logic                      dout,
    output logic                      cs_n,
    output logic                      busy,
    output logic                      res_valid,
    output logic [2:0]                res_ch,
    output logic [DATA_BITS-1:0]      res_data,
    output logic                      scan_done,
    output logic [N_CH*DATA_BITS-1:0] res_bank
);

    localparam int c_frame   = 7 + DATA_BITS;
    localparam int c_cnt_max = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_hp_w    = $clog2(2 * c_frame + 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(CS_GAP - 1);
    localparam logic [c_hp_w-1:0]  c_hp_last  = c_hp_w'(2 * c_frame);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_LATCH = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [c_cnt_w-1:0]        cnt_q, cnt_d;
    logic [c_hp_w-1:0]         hp_q, hp_d;
    logic [N_CH-1:0]           mask_q, mask_d;
    logic [2:0]                ch_q, ch_d;
    logic [DATA_BITS-1:0]      shreg_q, shreg_d;
    logic                      sclk_q, sclk_d;
    logic                      din_q, din_d;
    logic                      cs_n_q, cs_n_d;
    logic                      busy_q, busy_d;
    logic                      res_valid_q, res_valid_d;
    logic [2:0]                res_ch_q, res_ch_d;
    logic [DATA_BITS-1:0]      res_data_q, res_data_d;
    logic                      scan_done_q, scan_done_d;
    logic [N_CH*DATA_BITS-1:0] bank_q, bank_d;
    logic                      start_prev_q, start_prev_d;

    logic                      w_start_rise;
    logic                      w_launch;
    logic [N_CH-1:0]           w_launch_mask;
    logic                      w_gap_end;
    logic [N_CH-1:0]           w_rem;
    int                        w_hp_idx;

    function automatic logic [2:0] lowest_ch(input logic [N_CH-1:0] m);
        lowest_ch = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (m[k]) lowest_ch = 3'(k);
        end
    endfunction

    // Command word clocked out MSB-first: start, SGL/DIFF, D2, D1, D0.
    function automatic logic cmd_bit(input int idx, input logic [2:0] ch);
        case (idx)
            1:       cmd_bit = 1'b1;
            2:       cmd_bit = (DIFF == 0);
            3:       cmd_bit = ch[2];
            4:       cmd_bit = ch[1];
            5:       cmd_bit = ch[0];
            default: cmd_bit = 1'b0;
        endcase
    endfunction

    assign w_start_rise = start & ~start_prev_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hp_d          = hp_q;
        mask_d        = mask_q;
        ch_d          = ch_q;
        shreg_d       = shreg_q;
        sclk_d        = sclk_q;
        din_d         = din_q;
        cs_n_d        = cs_n_q;
        busy_d        = busy_q;
        res_valid_d   = 1'b0;
        res_ch_d      = res_ch_q;
        res_data_d    = res_data_q;
        scan_done_d   = 1'b0;
        bank_d        = bank_q;
        start_prev_d  = start;
        w_launch      = 1'b0;
        w_launch_mask = '0;
        w_gap_end     = 1'b0;
        w_rem         = mask_q;
        w_hp_idx      = int'(hp_q) / 2 + 1;

        case (state_q)
            S_IDLE: begin
                if (w_start_rise && ch_mask != '0) begin
                    w_launch      = 1'b1;
                    w_launch_mask = ch_mask;
                    busy_d        = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == c_div_last) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    hp_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // Even half-periods are sclk low, odd are high; the last even one is the trailing low.
                if (cnt_q == c_div_last) begin
                    cnt_d = '0;
                    if (hp_q == c_hp_last) begin
                        state_d = S_LATCH;
                        cs_n_d  = 1'b1;
                        din_d   = 1'b0;
                    end else begin
                        hp_d = hp_q + 1'b1;
                        if (!hp_q[0]) begin
                            sclk_d = 1'b1;
                            if (w_hp_idx >= 8) shreg_d = {shreg_q[DATA_BITS-2:0], dout};
                        end else begin
                            sclk_d = 1'b0;
                            din_d  = cmd_bit(w_hp_idx + 1, ch_q);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                res_valid_d = 1'b1;
                res_ch_d    = ch_q;
                res_data_d  = shreg_q;
                for (int k = 0; k < N_CH; k++) begin
                    if (int'(ch_q) == k) begin
                        w_rem[k]                         = 1'b0;
                        bank_d[k*DATA_BITS +: DATA_BITS] = shreg_q;
                    end
                end
                mask_d      = w_rem;
                scan_done_d = (w_rem == '0);
                // The LATCH cycle is the first of the CS_GAP high cycles.
                if (CS_GAP == 1) begin
                    w_gap_end = 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = c_cnt_w'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == c_gap_last) w_gap_end = 1'b1;
                else                     cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_gap_end) begin
            if (w_rem != '0) begin
                w_launch      = 1'b1;
                w_launch_mask = w_rem;
            end else if (continuous && ch_mask != '0) begin
                w_launch      = 1'b1;
                w_launch_mask = ch_mask;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end

        if (w_launch) begin
            mask_d  = w_launch_mask;
            ch_d    = lowest_ch(w_launch_mask);
            state_d = S_SETUP;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            din_d   = 1'b1;
            sclk_d  = 1'b0;
        end
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hp_q         <= '0;
            mask_q       <= '0;
            ch_q         <= '0;
            shreg_q      <= '0;
            sclk_q       <= 1'b0;
            din_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_ch_q     <= '0;
            res_data_q   <= '0;
            scan_done_q  <= 1'b0;
            bank_q       <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hp_q         <= hp_d;
            mask_q       <= mask_d;
            ch_q         <= ch_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            res_ch_q     <= res_ch_d;
            res_data_q   <= res_data_d;
            scan_done_q  <= scan_done_d;
            bank_q       <= bank_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign sclk      = sclk_q;
    assign din       = din_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign scan_done = scan_done_q;
    assign res_bank  = bank_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3x08_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_mcp3x08_scanner                                         |
// | Description : Bench for mcp3x08_scanner with a behavioural ADC model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mcp3x08_scanner;

    logic        dclk = 1'b0;
    logic        rst  = 1'b1;
    logic        dout = 1'b0;

    logic        start_a = 1'b0, cont_a = 1'b0;
    logic [7:0]  mask_a = '0;
    logic        sclk_a, din_a, cs_n_a, busy_a, rv_a, sd_a;
    logic [2:0]  rch_a;
    logic [9:0]  rdata_a;
    logic [79:0] bank_a;

    logic        start_b = 1'b0, cont_b = 1'b0;
    logic [3:0]  mask_b = '0;
    logic        sclk_b, din_b, cs_n_b, busy_b, rv_b, sd_b;
    logic [2:0]  rch_b;
    logic [11:0] rdata_b;
    logic [47:0] bank_b;

    mcp3x08_scanner #(.DATA_BITS(10), .N_CH(8), .CLK_DIV(4), .CS_GAP(8), .DIFF(0)) u_dut_a (
        .dclk(dclk), .rst(rst), .start(start_a), .continuous(cont_a), .ch_mask(mask_a),
        .sclk(sclk_a), .din(din_a), .dout(dout), .cs_n(cs_n_a), .busy(busy_a),
        .res_valid(rv_a), .res_ch(rch_a), .res_data(rdata_a), .scan_done(sd_a), .res_bank(bank_a)
    );

    mcp3x08_scanner #(.DATA_BITS(12), .N_CH(4), .CLK_DIV(1), .CS_GAP(3), .DIFF(1)) u_dut_b (
        .dclk(dclk), .rst(rst), .start(start_b), .continuous(cont_b), .ch_mask(mask_b),
        .sclk(sclk_b), .din(din_b), .dout(dout), .cs_n(cs_n_b), .busy(busy_b),
        .res_valid(rv_b), .res_ch(rch_b), .res_data(rdata_b), .scan_done(sd_b), .res_bank(bank_b)
    );

    // Only one scanner is active at a time, so the idle one's outputs are neutral here.
    logic        sclk_m, din_m, cs_n_m, busy_m, rv_m, sd_m;
    logic [2:0]  rch_m;
    logic [15:0] rdata_m;
    assign sclk_m  = sclk_a | sclk_b;
    assign din_m   = din_a | din_b;
    assign cs_n_m  = cs_n_a & cs_n_b;
    assign busy_m  = busy_a | busy_b;
    assign rv_m    = rv_a | rv_b;
    assign sd_m    = sd_a | sd_b;
    assign rch_m   = rv_b ? rch_b : rch_a;
    assign rdata_m = rv_b ? 16'(rdata_b) : 16'(rdata_a);

    typedef struct packed { logic [2:0] ch; logic [15:0] data; logic sd; } res_t;
    typedef struct packed { logic [7:0] rises; logic [4:0] cmd; logic [15:0] low; } frm_t;

    res_t        rq[$];
    frm_t        fq[$];
    int          checks = 0, errors = 0;
    int          rise_cnt = 0, low_cnt = 0, cur_bits = 10;
    int          sd_cnt = 0, stray_sd = 0, gap_meas = 0;
    logic [4:0]  cmd_sh = '0;
    logic [15:0] adc_val [8];
    logic [15:0] bank_m  [8];
    time         t_cs_rise = 0;

    always #5 dclk = ~dclk;

    // ADC model: decodes the command word, then returns adc_val[channel] MSB-first.
    always @(negedge cs_n_m) begin
        rise_cnt = 0;
        cmd_sh   = '0;
        low_cnt  = 0;
    end

    always @(posedge sclk_m) begin
        if (!cs_n_m) begin
            rise_cnt++;
            if (rise_cnt <= 5) cmd_sh = {cmd_sh[3:0], din_m};
        end
    end

    always @(negedge sclk_m) begin
        if (!cs_n_m && rise_cnt >= 7 && rise_cnt < 7 + cur_bits)
            dout = adc_val[cmd_sh[2:0]][cur_bits - 1 - (rise_cnt - 7)];
        else
            dout = 1'b0;
    end

    always @(posedge cs_n_m) begin
        fq.push_back('{rises: 8'(rise_cnt), cmd: cmd_sh, low: 16'(low_cnt)});
        t_cs_rise = $time;
    end

    always @(negedge busy_m) gap_meas = int'(($time - t_cs_rise) / 10);

    always @(negedge dclk) begin
        if (!cs_n_m) low_cnt++;
        if (rv_m) rq.push_back('{ch: rch_m, data: rdata_m, sd: sd_m});
        if (sd_m) sd_cnt++;
        if (sd_m && !rv_m) stray_sd++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        rq.delete();
        fq.delete();
        sd_cnt   = 0;
        stray_sd = 0;
    endtask

    task automatic do_reset();
        @(negedge dclk) rst = 1'b1;
        repeat (2) @(negedge dclk);
        rst = 1'b0;
        flush();
        for (int k = 0; k < 8; k++) bank_m[k] = '0;
    endtask

    task automatic pulse_start(input int inst);
        @(negedge dclk);
        if (inst == 0) start_a = 1'b1;
        else           start_b = 1'b1;
        repeat (2) @(negedge dclk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        repeat (4) @(negedge dclk);
        while (busy_m === 1'b1 && n < max_cyc) begin
            @(negedge dclk);
            n++;
        end
        chk("idle_timeout", 64'(n >= max_cyc), 64'd0);
    endtask

    // Reference: one frame per set mask bit, ascending, data straight from the ADC model.
    task automatic check_scan(input string tag, input int inst, input logic [7:0] mask);
        int   bits, nch, cdiv, exp_ch[$];
        logic sgl;
        res_t r;
        frm_t f;
        logic [63:0] obs;
        bits = (inst == 0) ? 10 : 12;
        nch  = (inst == 0) ? 8 : 4;
        cdiv = (inst == 0) ? 4 : 1;
        sgl  = (inst == 0);
        for (int k = 0; k < nch; k++) if (mask[k]) exp_ch.push_back(k);
        chk({tag, "_results"}, 64'(rq.size()), 64'(exp_ch.size()));
        chk({tag, "_frames"},  64'(fq.size()), 64'(exp_ch.size()));
        for (int i = 0; i < exp_ch.size(); i++) begin
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk({tag, "_ch"},   64'(r.ch),   64'(exp_ch[i]));
                chk({tag, "_data"}, 64'(r.data), 64'(adc_val[exp_ch[i]]));
                chk({tag, "_done"}, 64'(r.sd),   64'(i == exp_ch.size() - 1));
            end
            if (fq.size() > 0) begin
                f = fq.pop_front();
                chk({tag, "_rises"}, 64'(f.rises), 64'(7 + bits));
                chk({tag, "_cmd"},   64'(f.cmd),   64'({1'b1, sgl, 3'(exp_ch[i])}));
                chk({tag, "_cslow"}, 64'(f.low),   64'(2 * cdiv * (8 + bits)));
            end
            bank_m[exp_ch[i]] = adc_val[exp_ch[i]];
        end
        chk({tag, "_scan_done_cnt"}, 64'(sd_cnt), 64'd1);
        chk({tag, "_stray_done"},    64'(stray_sd), 64'd0);
        for (int k = 0; k < nch; k++) begin
            obs = (inst == 0) ? 64'(bank_a[k*10 +: 10]) : 64'(bank_b[k*12 +: 12]);
            chk({tag, "_bank"}, obs, 64'(bank_m[k]));
        end
        flush();
    endtask

    task automatic run_scan(input string tag, input int inst, input logic [7:0] mask);
        if (inst == 0) mask_a = mask;
        else           mask_b = mask[3:0];
        pulse_start(inst);
        wait_idle(3000);
        check_scan(tag, inst, mask);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        res_t r;
        for (int k = 0; k < 8; k++) begin
            adc_val[k] = '0;
            bank_m[k]  = '0;
        end

        // Reset values
        repeat (3) @(negedge dclk);
        chk("rst_cs_n",   64'(cs_n_a),  64'd1);
        chk("rst_sclk",   64'(sclk_a),  64'd0);
        chk("rst_din",    64'(din_a),   64'd0);
        chk("rst_busy",   64'(busy_a),  64'd0);
        chk("rst_valid",  64'(rv_a),    64'd0);
        chk("rst_done",   64'(sd_a),    64'd0);
        chk("rst_res_ch", 64'(rch_a),   64'd0);
        chk("rst_data",   64'(rdata_a), 64'd0);
        chk("rst_bank",   64'(bank_a),  64'd0);
        chk("rst_b_cs_n", 64'(cs_n_b),  64'd1);
        chk("rst_b_bank", 64'(bank_b),  64'd0);
        rst = 1'b0;
        flush();

        // Single channel 0, known value
        adc_val[0] = 16'h2A5;
        run_scan("single", 0, 8'h01);
        chk("single_gap", 64'(gap_meas), 64'd8);
        chk("single_res_data_hold", 64'(rdata_a), 64'h2A5);

        // Sparse mask, data = ch*16+3
        do_reset();
        for (int k = 0; k < 8; k++) adc_val[k] = 16'(k * 16 + 3);
        run_scan("sparse", 0, 8'b1010_0100);

        // Randomised scans
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 8; k++) adc_val[k] = 16'($urandom_range(0, 1023));
            run_scan("rand_a", 0, 8'($urandom_range(1, 255)));
        end

        // Start with empty mask is ignored
        mask_a = 8'h00;
        pulse_start(0);
        repeat (20) @(negedge dclk);
        chk("mask0_busy",    64'(busy_m),    64'd0);
        chk("mask0_results", 64'(rq.size()), 64'd0);
        chk("mask0_frames",  64'(fq.size()), 64'd0);

        // Second start edge during a scan adds no frames
        adc_val[4] = 16'($urandom_range(0, 1023));
        mask_a = 8'h10;
        pulse_start(0);
        repeat (40) @(negedge dclk);
        pulse_start(0);
        wait_idle(3000);
        check_scan("restart_ignored", 0, 8'h10);

        // Continuous 0,1,0,1 then drop continuous
        adc_val[0] = 16'($urandom_range(0, 1023));
        adc_val[1] = 16'($urandom_range(0, 1023));
        mask_a = 8'h03;
        cont_a = 1'b1;
        pulse_start(0);
        n = 0;
        while (rq.size() < 3 && n < 3000) begin
            @(negedge dclk);
            n++;
        end
        cont_a = 1'b0;
        chk("cont_wait_timeout", 64'(n >= 3000), 64'd0);
        wait_idle(3000);
        chk("cont_results", 64'(rq.size()), 64'd4);
        chk("cont_frames",  64'(fq.size()), 64'd4);
        chk("cont_scan_done_cnt", 64'(sd_cnt), 64'd2);
        chk("cont_gap", 64'(gap_meas), 64'd8);
        n = rq.size();
        for (int i = 0; i < n; i++) begin
            r = rq.pop_front();
            chk("cont_ch",   64'(r.ch),   64'(i % 2));
            chk("cont_data", 64'(r.data), 64'(adc_val[i % 2]));
            chk("cont_done", 64'(r.sd),   64'(i % 2));
        end
        flush();

        // Reset in the middle of SHIFT
        mask_a = 8'h80;
        pulse_start(0);
        n = 0;
        while (rise_cnt < 3 && n < 500) begin
            @(negedge dclk);
            n++;
        end
        chk("midrst_wait_timeout", 64'(n >= 500), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", 64'(cs_n_a), 64'd1);
        chk("midrst_sclk", 64'(sclk_a), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        repeat (2) @(negedge dclk);
        rst = 1'b0;
        chk("midrst_bank", 64'(bank_a),  64'd0);
        chk("midrst_data", 64'(rdata_a), 64'd0);
        repeat (200) @(negedge dclk);
        chk("midrst_no_result", 64'(rq.size()), 64'd0);
        chk("midrst_idle",      64'(busy_m),    64'd0);
        flush();
        for (int k = 0; k < 8; k++) bank_m[k] = '0;

        // 12-bit, CLK_DIV=1, N_CH=4, pseudo-differential instance
        cur_bits = 12;
        do_reset();
        adc_val[3] = 16'hABC;
        run_scan("b_ch3", 1, 8'h08);
        chk("b_gap", 64'(gap_meas), 64'd3);
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 4; k++) adc_val[k] = 16'($urandom_range(0, 4095));
            run_scan("rand_b", 1, 8'($urandom_range(1, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
